// File: rtl/dht11_reader_if.sv
// Host-side handshake and result bundle of the DHT11 reader.
// The reader is the slave; the display formatter or test host is the master.
interface dht11_reader_if;
  logic       start;
  logic       busy;
  logic       valid;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;

  modport master (
    output start,
    input  busy, valid, err, err_code, hum_int, hum_dec, temp_int, temp_dec
  );

  modport slave (
    input  start,
    output busy, valid, err, err_code, hum_int, hum_dec, temp_int, temp_dec
  );
endinterface

// File: rtl/dht11_reader.sv
// DHT11 single-wire acquisition engine: host start pulse, response and 40-bit
// frame timing on a 1 us tick, checksum verification and result registers.
module dht11_reader #(
  parameter int unsigned CLK_PER_US    = 100,
  parameter int unsigned START_US      = 18000,
  parameter int unsigned BIT_THRESH_US = 40,
  parameter int unsigned TIMEOUT_US    = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dht_in,
  output logic          dht_oe,
  dht11_reader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStartLow,
    StRelease,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StCheck
  } state_e;

  localparam int unsigned   PW          = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_PER_US - 1);
  localparam logic [14:0]   START_CNT   = 15'(START_US);
  localparam logic [14:0]   THRESH_CNT  = 15'(BIT_THRESH_US);
  localparam logic [14:0]   TIMEOUT_CNT = 15'(TIMEOUT_US);
  // Our own low drive is still in the synchronizer just after release.
  localparam logic [14:0]   BLANK_CNT   = 15'd2;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_line;
  logic [PW-1:0] r_presc;
  logic          w_us_tick;
  logic [14:0]   r_us_cnt;
  state_e        r_state;
  state_e        w_state_d;
  logic          w_timeout;
  logic          w_timeout_exit;
  logic          w_shift_en;
  logic          w_bit;
  logic [5:0]    r_bit_cnt;
  logic [39:0]   r_shift;
  logic [7:0]    w_sum;
  logic          w_sum_ok;
  logic          r_dht_oe;
  logic          r_valid;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [7:0]    r_hum_int;
  logic [7:0]    r_hum_dec;
  logic [7:0]    r_temp_int;
  logic [7:0]    r_temp_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= dht_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line    = r_sync2;
  assign w_us_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_us_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_us_cnt <= '0;
    end else if ((w_state_d != r_state) || (r_state == StIdle)) begin
      r_us_cnt <= '0;
    end else if (w_us_tick) begin
      r_us_cnt <= r_us_cnt + 15'd1;
    end
  end

  assign w_timeout = (r_us_cnt >= TIMEOUT_CNT);
  assign w_bit     = (r_us_cnt > THRESH_CNT);
  assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
  assign w_sum_ok  = (w_sum == r_shift[7:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_timeout_exit = 1'b0;
    w_shift_en     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) w_state_d = StStartLow;
      end
      StStartLow: begin
        if (r_us_cnt >= START_CNT) w_state_d = StRelease;
      end
      StRelease: begin
        if (w_timeout) begin
          w_timeout_exit = 1'b1;
        end else if (!w_line && (r_us_cnt >= BLANK_CNT)) begin
          w_state_d = StRespLow;
        end
      end
      StRespLow: begin
        if (w_timeout) w_timeout_exit = 1'b1;
        else if (w_line) w_state_d = StRespHigh;
      end
      StRespHigh: begin
        if (w_timeout) w_timeout_exit = 1'b1;
        else if (!w_line) w_state_d = StBitLow;
      end
      StBitLow: begin
        if (w_timeout) w_timeout_exit = 1'b1;
        else if (w_line) w_state_d = StBitHigh;
      end
      StBitHigh: begin
        if (w_timeout) begin
          w_timeout_exit = 1'b1;
        end else if (!w_line) begin
          w_shift_en = 1'b1;
          w_state_d  = (r_bit_cnt == 6'd39) ? StCheck : StBitLow;
        end
      end
      StCheck: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    if (w_timeout_exit) w_state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dht_oe   <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_hum_int  <= '0;
      r_hum_dec  <= '0;
      r_temp_int <= '0;
      r_temp_dec <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_dht_oe <= (w_state_d == StStartLow);
      if ((r_state == StIdle) && bus.start) begin
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_err_code <= 2'b00;
      end
      if (w_shift_en) begin
        r_shift   <= {r_shift[38:0], w_bit};
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      if (w_timeout_exit) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b01;
      end
      if (r_state == StCheck) begin
        if (w_sum_ok) begin
          r_valid    <= 1'b1;
          r_hum_int  <= r_shift[39:32];
          r_hum_dec  <= r_shift[31:24];
          r_temp_int <= r_shift[23:16];
          r_temp_dec <= r_shift[15:8];
        end else begin
          r_err      <= 1'b1;
          r_err_code <= 2'b10;
        end
      end
    end
  end

  assign dht_oe       = r_dht_oe;
  assign bus.busy     = (r_state != StIdle);
  assign bus.valid    = r_valid;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;
  assign bus.hum_int  = r_hum_int;
  assign bus.hum_dec  = r_hum_dec;
  assign bus.temp_int = r_temp_int;
  assign bus.temp_dec = r_temp_dec;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a behavioural DHT11 sensor drives directed and random frames,
// results are compared against a checksum/hold model of the expected outputs.
`timescale 1ns/1ps
module tb_dht11_reader;
  localparam int unsigned CLK_PER_US    = 2;
  localparam int unsigned START_US      = 180;
  localparam int unsigned BIT_THRESH_US = 40;
  localparam int unsigned TIMEOUT_US    = 200;
  localparam int          US_NS         = 10 * CLK_PER_US;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sensor_drv = 1'b1;
  logic dht_oe;
  logic dht_in;

  // Open-drain line with pull-up: low whenever either side drives.
  assign dht_in = dht_oe ? 1'b0 : sensor_drv;

  dht11_reader_if bus ();

  dht11_reader #(
    .CLK_PER_US   (CLK_PER_US),
    .START_US     (START_US),
    .BIT_THRESH_US(BIT_THRESH_US),
    .TIMEOUT_US   (TIMEOUT_US)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dht_in(dht_in),
    .dht_oe(dht_oe),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int valid_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int busy_at_pulse = 0;

  always @(negedge clk) begin
    if (bus.valid) valid_cnt <= valid_cnt + 1;
    if (bus.err) err_cnt <= err_cnt + 1;
    if (bus.valid && bus.err) overlap_cnt <= overlap_cnt + 1;
    if ((bus.valid || bus.err) && bus.busy) busy_at_pulse <= busy_at_pulse + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_hum_int, exp_hum_dec, exp_temp_int, exp_temp_dec;
  logic [1:0] exp_code;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_oe(input logic lvl, input int max_cyc, output bit ok);
    ok = (dht_oe === lvl);
    for (int i = 0; (i < max_cyc) && !ok; i++) begin
      @(negedge clk);
      ok = (dht_oe === lvl);
    end
  endtask

  task automatic wait_result(input int base, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; (i < max_cyc) && !ok; i++) begin
      @(negedge clk);
      ok = ((valid_cnt + err_cnt) > base);
    end
  endtask

  // nbits: 40 = full frame, 0..39 = sensor stalls high, -1 = no response at all.
  task automatic do_read(input logic [39:0] frame, input int nbits, input int poke);
    int      v0, e0, w;
    bit      ok, good;
    realtime t0, t_ref;
    v0 = valid_cnt;
    e0 = err_cnt;
    pulse_start();
    wait_oe(1'b1, 10, ok);
    check("oe_rise", ok, 1);
    t0 = $realtime;
    wait_oe(1'b0, (START_US + 20) * CLK_PER_US, ok);
    check("oe_fall", ok, 1);
    w = int'(($realtime - t0) / US_NS);
    check("start_width_ok", (w >= START_US - 1) && (w <= START_US + 1), 1);
    t_ref = $realtime;
    if (nbits >= 0) begin
      #(30 * US_NS) sensor_drv = 1'b0;
      #(80 * US_NS) sensor_drv = 1'b1;
      #(80 * US_NS);
      for (int i = 0; i < nbits; i++) begin
        sensor_drv = 1'b0;
        if (i == poke) begin
          #(20 * US_NS) bus.start = 1'b1;
          #10 bus.start = 1'b0;
          #(30 * US_NS - 10);
        end else begin
          #(50 * US_NS);
        end
        sensor_drv = 1'b1;
        t_ref = $realtime;
        #((frame[39-i] ? 70 : 24) * US_NS);
      end
      if (nbits == 40) begin
        sensor_drv = 1'b0;
        #(50 * US_NS) sensor_drv = 1'b1;
      end
    end
    wait_result(v0 + e0, (TIMEOUT_US + 20) * CLK_PER_US, ok);
    check("result_seen", ok, 1);
    if (nbits == 40) begin
      good = frame_ok(frame);
      if (good) begin
        exp_hum_int  = frame[39:32];
        exp_hum_dec  = frame[31:24];
        exp_temp_int = frame[23:16];
        exp_temp_dec = frame[15:8];
        exp_code     = 2'b00;
      end else begin
        exp_code = 2'b10;
      end
    end else begin
      good     = 1'b0;
      exp_code = 2'b01;
      w = int'(($realtime - t_ref) / US_NS);
      check("timeout_width_ok", (w >= TIMEOUT_US - 1) && (w <= TIMEOUT_US + 3), 1);
    end
    repeat (4) @(negedge clk);
    check("valid_count", valid_cnt - v0, good ? 1 : 0);
    check("err_count", err_cnt - e0, good ? 0 : 1);
    check("err_code", bus.err_code, exp_code);
    check("hum_int", bus.hum_int, exp_hum_int);
    check("hum_dec", bus.hum_dec, exp_hum_dec);
    check("temp_int", bus.temp_int, exp_temp_int);
    check("temp_dec", bus.temp_dec, exp_temp_dec);
    check("busy_after", bus.busy, 0);
    check("oe_after", dht_oe, 0);
  endtask

  initial begin
    logic [39:0] f;
    logic [7:0]  sum8;
    int          v0, e0;
    bit          ok;

    bus.start = 1'b0;
    exp_hum_int  = 8'h00;
    exp_hum_dec  = 8'h00;
    exp_temp_int = 8'h00;
    exp_temp_dec = 8'h00;
    exp_code     = 2'b00;

    #2 rst = 1'b0;
    #1;
    check("rst_oe", dht_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_code", bus.err_code, 0);
    check("rst_hum", bus.hum_int, 0);
    check("rst_temp", bus.temp_int, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    do_read(40'h37_00_19_00_50, 40, -1);
    do_read(40'h37_00_19_00_51, 40, -1);

    for (int k = 0; k < 2; k++) begin
      f[39:8] = $urandom;
      sum8    = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      f[7:0]  = ($urandom_range(0, 1) == 1) ? sum8 : sum8 + 8'($urandom_range(1, 255));
      do_read(f, 40, -1);
    end

    do_read(40'h0, -1, -1);
    do_read(40'hA5_5A_C3_3C_00, 20, -1);

    f[39:8] = $urandom;
    f[7:0]  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    do_read(f, 40, 10);

    // Reset while the host start pulse is being driven.
    v0 = valid_cnt;
    e0 = err_cnt;
    pulse_start();
    wait_oe(1'b1, 10, ok);
    check("mid_oe_rise", ok, 1);
    #(50 * US_NS + 3) rst = 1'b0;
    #1;
    check("mid_rst_oe", dht_oe, 0);
    check("mid_rst_busy", bus.busy, 0);
    exp_hum_int  = 8'h00;
    exp_hum_dec  = 8'h00;
    exp_temp_int = 8'h00;
    exp_temp_dec = 8'h00;
    repeat (20) @(negedge clk);
    check("mid_rst_no_valid", valid_cnt - v0, 0);
    check("mid_rst_no_err", err_cnt - e0, 0);
    check("mid_rst_hum", bus.hum_int, exp_hum_int);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_read(40'h37_00_19_00_50, 40, -1);

    check("valid_err_overlap", overlap_cnt, 0);
    check("busy_at_pulse", busy_at_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
